// File: rtl/tpu_pkg.sv
// Shared types and constants for the systolic-array output datapath.
//   TPU_ACC_W / TPU_DATA_W : default accumulator and activation widths
//   INT8_MIN / INT8_MAX    : clamp bounds for INT8 activations
//   acc_t / int8_t         : signed accumulator and activation types
package tpu_pkg;

    localparam int TPU_ACC_W  = 32;
    localparam int TPU_DATA_W = 8;

    localparam int INT8_MIN = -128;
    localparam int INT8_MAX = 127;

    typedef logic signed [TPU_ACC_W-1:0]  acc_t;
    typedef logic signed [TPU_DATA_W-1:0] int8_t;

endpackage

// File: rtl/requant_lane.sv
// One lane of the requantizer: three registered stages sharing one enable.
//   stage 1: prod = acc * mult (full width)
//   stage 2: rounding arithmetic right shift of prod by shift
//   stage 3: add zero point, clamp to INT8
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   en        : pipeline advance (all stages move together)
//   acc       : signed accumulator entering stage 1
//   mult      : signed scale used by stage 1
//   shift     : shift amount for the beat in stage 1 (already limited to P-1)
//   zp        : zero point for the beat in stage 2
//   data      : registered INT8 result
//   sat       : combinational flag, high when the beat leaving stage 2 clamps
module requant_lane
    import tpu_pkg::*;
#(
    parameter int ACC_W   = 32,
    parameter int MULT_W  = 16,
    parameter int SHIFT_W = 6,
    parameter int DATA_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [ACC_W-1:0]   acc,
    input  logic [MULT_W-1:0]  mult,
    input  logic [SHIFT_W-1:0] shift,
    input  logic [DATA_W-1:0]  zp,
    output logic [DATA_W-1:0]  data,
    output logic               sat
);

    localparam int P = ACC_W + MULT_W;
    localparam int8_t SAT_HI = int8_t'(INT8_MAX);
    localparam int8_t SAT_LO = int8_t'(INT8_MIN);

    logic signed [P-1:0]  prod_reg, prod_next;
    logic        [P:0]    rnd_bias;
    logic signed [P:0]    rnd_sum;
    logic signed [P:0]    rnd_reg, rnd_next;
    logic signed [P+1:0]  zp_sum;
    logic [DATA_W-1:0]    data_reg, data_next;
    logic                 sat_next;

    // Both operands sign-extended to P bits so the truncated product is exact.
    assign prod_next = $signed({{MULT_W{acc[ACC_W-1]}}, acc}) *
                       $signed({{ACC_W{mult[MULT_W-1]}}, mult});

    // Half-LSB bias; zero when shift is zero so the same path yields prod unchanged.
    always_comb begin
        rnd_bias = '0;
        if (shift != '0) begin
            rnd_bias = {{P{1'b0}}, 1'b1} << (shift - SHIFT_W'(1));
        end
    end

    // One extra bit of headroom keeps prod + bias from overflowing.
    assign rnd_sum  = $signed({prod_reg[P-1], prod_reg}) + $signed(rnd_bias);
    assign rnd_next = rnd_sum >>> shift;

    assign zp_sum = $signed({rnd_reg[P], rnd_reg}) +
                    $signed({{(P+2-DATA_W){zp[DATA_W-1]}}, zp});

    always_comb begin
        data_next = zp_sum[DATA_W-1:0];
        sat_next  = 1'b0;
        if (zp_sum > $signed((P+2)'(INT8_MAX))) begin
            data_next = DATA_W'(SAT_HI);
            sat_next  = 1'b1;
        end else if (zp_sum < $signed((P+2)'(INT8_MIN))) begin
            data_next = DATA_W'(SAT_LO);
            sat_next  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_reg <= '0;
            rnd_reg  <= '0;
            data_reg <= '0;
        end else if (en) begin
            prod_reg <= prod_next;
            rnd_reg  <= rnd_next;
            data_reg <= data_next;
        end
    end

    assign data = data_reg;
    assign sat  = sat_next;

endmodule

// File: rtl/requant_int8.sv
// INT8 requantizer behind the systolic array MAC columns.
// Per lane: multiply by scale, rounding right shift, zero-point add, saturate.
// Three-stage pipeline with valid/ready backpressure; latency 3, 1 beat/cycle.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake (in_ready depends only on output side)
//   in_acc              : LANES packed signed accumulators, lane i at [i*ACC_W +: ACC_W]
//   cfg_we              : load cfg_mult/cfg_shift/cfg_zp (old values apply to a beat
//                         accepted in the same cycle)
//   sat_clr             : clear saturation counter (wins over increment)
//   out_valid/out_ready : output handshake
//   out_data            : LANES packed signed INT8 results
//   sat_count           : clamped lanes since last clear, sticks at all-ones
//   busy                : any stage holds a valid beat
module requant_int8
    import tpu_pkg::*;
#(
    parameter int LANES   = 4,
    parameter int ACC_W   = TPU_ACC_W,
    parameter int MULT_W  = 16,
    parameter int SHIFT_W = 6,
    parameter int DATA_W  = TPU_DATA_W,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*ACC_W-1:0]    in_acc,
    input  logic                      cfg_we,
    input  logic [MULT_W-1:0]         cfg_mult,
    input  logic [SHIFT_W-1:0]        cfg_shift,
    input  logic [DATA_W-1:0]         cfg_zp,
    input  logic                      sat_clr,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*DATA_W-1:0]   out_data,
    output logic [CNT_W-1:0]          sat_count,
    output logic                      busy
);

    localparam int P  = ACC_W + MULT_W;
    localparam int NW = $clog2(LANES + 1);
    localparam logic [SHIFT_W-1:0] SHIFT_MAX = SHIFT_W'(P - 1);

    logic                adv;
    logic                v1_reg, v2_reg, v3_reg;
    logic [MULT_W-1:0]   mult_reg;
    logic [SHIFT_W-1:0]  shift_reg, shift_eff, sh1_reg;
    logic [DATA_W-1:0]   zp_reg, zp1_reg, zp2_reg;
    logic [LANES-1:0]    sat_vec;
    logic [NW-1:0]       sat_lanes;
    logic [CNT_W:0]      cnt_sum;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;

    // Only a held output beat that downstream refuses can stall the pipe.
    assign adv      = !(v3_reg && !out_ready);
    assign in_ready = adv;

    // Shifts past the product width would discard everything; pin them to P-1.
    assign shift_eff = (int'(shift_reg) >= P) ? SHIFT_MAX : shift_reg;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            requant_lane #(
                .ACC_W   (ACC_W),
                .MULT_W  (MULT_W),
                .SHIFT_W (SHIFT_W),
                .DATA_W  (DATA_W)
            ) u_lane (
                .clk   (clk),
                .rst   (rst),
                .en    (adv),
                .acc   (in_acc[gi*ACC_W +: ACC_W]),
                .mult  (mult_reg),
                .shift (sh1_reg),
                .zp    (zp2_reg),
                .data  (out_data[gi*DATA_W +: DATA_W]),
                .sat   (sat_vec[gi])
            );
        end
    endgenerate

    always_comb begin
        sat_lanes = '0;
        for (int i = 0; i < LANES; i++) begin
            sat_lanes = sat_lanes + NW'(sat_vec[i]);
        end
    end

    // Counter tracks beats as they enter the output register.
    always_comb begin
        cnt_sum  = {1'b0, cnt_reg} + (CNT_W+1)'(sat_lanes);
        cnt_next = cnt_reg;
        if (sat_clr) begin
            cnt_next = '0;
        end else if (adv && v2_reg) begin
            cnt_next = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_reg    <= 1'b0;
            v2_reg    <= 1'b0;
            v3_reg    <= 1'b0;
            mult_reg  <= MULT_W'(1);
            shift_reg <= '0;
            zp_reg    <= '0;
            sh1_reg   <= '0;
            zp1_reg   <= '0;
            zp2_reg   <= '0;
            cnt_reg   <= '0;
        end else begin
            if (cfg_we) begin
                mult_reg  <= cfg_mult;
                shift_reg <= cfg_shift;
                zp_reg    <= cfg_zp;
            end
            // shift/zp travel with their beat so config writes never touch in-flight data.
            if (adv) begin
                v1_reg  <= in_valid;
                v2_reg  <= v1_reg;
                v3_reg  <= v2_reg;
                sh1_reg <= shift_eff;
                zp1_reg <= zp_reg;
                zp2_reg <= zp1_reg;
            end
            cnt_reg <= cnt_next;
        end
    end

    assign out_valid = v3_reg;
    assign sat_count = cnt_reg;
    assign busy      = v1_reg | v2_reg | v3_reg;

endmodule

// File: doc/requant_int8.md
Name: requant_int8

Overview:
- Output-side stage directly downstream of the INT8 MAC columns of the weight-stationary systolic array.
- Consumes LANES signed 32-bit accumulator results per beat and requantizes each lane to INT8: multiply by scale, rounding right-shift, zero-point add, saturate.
- Results feed the activation writeback path for the next layer.
- Three-stage pipeline with valid/ready backpressure, runtime-configurable scale, and a saturation counter.

Parameters:
- LANES, 4, number of parallel accumulator lanes (array columns)
- ACC_W, 32, accumulator input width, signed
- MULT_W, 16, scale multiplier width, signed
- SHIFT_W, 6, shift amount width, unsigned
- DATA_W, 8, output width, signed
- CNT_W, 16, saturation counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept a beat this cycle
- in_acc  in  LANES*ACC_W  packed signed accumulators; lane i at [i*ACC_W +: ACC_W]
- cfg_we  in  1  load cfg_mult/cfg_shift/cfg_zp
- cfg_mult  in  MULT_W  signed scale multiplier
- cfg_shift  in  SHIFT_W  right-shift amount
- cfg_zp  in  DATA_W  signed output zero point
- sat_clr  in  1  clear saturation counter
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts the beat
- out_data  out  LANES*DATA_W  packed signed INT8 results, same lane order as in_acc
- sat_count  out  CNT_W  lanes clamped since last clear; sticks at all-ones
- busy  out  1  any pipeline stage holds a valid beat

Behaviour:
- Single clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - out_valid=0, out_data=0, sat_count=0, busy=0.
  - All stage valid bits are 0.
  - Config registers reset to identity: mult=1, shift=0, zp=0.
- Handshake:
  - A beat transfers on in_valid && in_ready, or on out_valid && out_ready.
  - The pipeline advances when adv = !(out_valid && !out_ready).
  - in_ready = adv. This is combinational from out_valid/out_ready only; it does not depend on in_valid.
  - While stalled, out_data and out_valid are held stable and all stage contents are frozen.
- Latency:
  - A beat accepted at cycle t appears with out_valid=1 at t+3 when there is no stall.
  - Throughput is 1 beat/cycle.
  - Bubbles propagate as invalid stages; no beat is ever duplicated or dropped.
- Config:
  - cfg_we writes the config registers at the clock edge regardless of adv.
  - A beat accepted in the same cycle as cfg_we uses the OLD config. Beats accepted later use the new config.
  - Each beat carries its own shift/zp copy through the pipeline, so in-flight beats are unaffected by config changes.
- Stage 1: prod = acc * mult, signed, full width P = ACC_W+MULT_W.
- Stage 2: rounding right-shift.
  - If shift==0: r = prod.
  - Otherwise: r = (prod + 2^(shift-1)) >>> shift, arithmetic shift (round half toward +inf).
  - Compute the addition in P+1 bits; no overflow is allowed.
  - Shift values >= P are treated as P-1.
- Stage 3: s = r + sign-extended zp.
  - Clamp s to [-128, 127]; the clamp is symmetric-unaware, and -128 is legal.
  - Each clamped lane is flagged.
- sat_count:
  - Increments by the number of flagged lanes, evaluated when a beat enters the output register.
  - Saturates at 2^CNT_W-1.
  - sat_clr has priority over the increment in the same cycle.
- busy = OR of the stage-1, stage-2 and output valid bits.
- Reset mid-operation flushes all in-flight beats. No output is produced for them.

Decomposition:
- Shared package `tpu_pkg`:
  - ACC_W and DATA_W defaults
  - INT8_MIN/INT8_MAX constants
  - typedefs acc_t and int8_t
- One natural sub-module: `requant_lane`, holding the per-lane multiply/round/zp/clamp datapath with stage enables. It is instantiated LANES times.
- Handshake, valid bits, config shadows and the counter stay in the top level.

Test Plan:
- Reset identity: after reset, lane accs {100, -100, 300, -300} -> out {100, -100, 127, -128} at t+3; sat_count=2.
- Scale/round: cfg mult=3, shift=2, zp=0; accs {5, -5, 6, 0} -> {4, -4, 5, 0}.
- Zero point: mult=1, shift=0, zp=-10; accs {50, -120, 140, 0} -> {40, -128, 127, -10}; sat_count +2.
- Backpressure: 6 back-to-back beats with accs 1..6 and out_ready low for cycles 4-8 -> in_ready low while stalled, out_data stable, outputs 1..6 in order with none lost.
- Config mid-stream: cfg_we (mult=2) in the same cycle as accepting acc=10, then acc=10 on the next cycle -> outputs 10, then 20.
- Reset mid-operation: assert rst with 3 beats in flight -> out_valid=0, sat_count=0, busy=0 next cycle; a new beat afterwards uses identity config.
